// File: rtl/mem_pkg.sv
// Shared encodings for the data memory responder: funct3 codes, byte-enable
// patterns and the request FSM states.
package mem_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response bus between a load/store requester and the data memory.
interface data_mem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        MemRead;
    logic        MemWrite;
    logic [3:0]  BE;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        resp_err;

    modport master (
        output req_valid, MemRead, MemWrite, BE, funct3, addr, wdata,
        input  req_ready, resp_valid, rdata, resp_err
    );

    modport slave (
        input  req_valid, MemRead, MemWrite, BE, funct3, addr, wdata,
        output req_ready, resp_valid, rdata, resp_err
    );

endinterface

// File: rtl/load_align.sv
// Combinational load formatter: shifts the addressed lane down and extends it
// per funct3; flags unknown codes and misaligned half/word loads.
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data,
    output logic        err
);

    logic [31:0] w_shift;

    always_comb begin
        w_shift = word >> {offset, 3'b000};
        data    = '0;
        err     = 1'b0;
        case (funct3)
            F3_LB:  data = {{24{w_shift[7]}}, w_shift[7:0]};
            F3_LBU: data = {24'd0, w_shift[7:0]};
            F3_LH: begin
                data = {{16{w_shift[15]}}, w_shift[15:0]};
                err  = offset[0];
            end
            F3_LHU: begin
                data = {16'd0, w_shift[15:0]};
                err  = offset[0];
            end
            F3_LW: begin
                data = w_shift;
                err  = |offset;
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Word-organised data memory with a single outstanding request, fixed response
// latency, byte/half/word stores and aligned, extended loads.
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    data_mem_responder_if.slave  bus
);

    localparam int unsigned IdxW = $clog2(DEPTH);
    localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    state_e            r_state;
    state_e            w_state_next;
    logic [CntW-1:0]   r_cnt;
    logic              r_read;
    logic              r_write;
    logic [3:0]        r_be;
    logic [2:0]        r_funct3;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_mem [DEPTH];

    logic              w_idle;
    logic              w_read;
    logic              w_write;
    logic [3:0]        w_be;
    logic [2:0]        w_funct3;
    logic [31:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [IdxW-1:0]   w_idx;
    logic [1:0]        w_off;
    logic              w_base_err;
    logic              w_align_err;
    logic              w_err;
    logic [31:0]       w_word;
    logic [31:0]       w_load_data;
    logic [3:0]        w_mask;
    logic [31:0]       w_wshift;
    logic              w_commit;
    logic              w_resp;

    // In IDLE the live inputs are the request being accepted (needed when
    // LATENCY=0 commits a store on the accepting edge); afterwards the latch.
    assign w_idle   = (r_state == StIdle);
    assign w_read   = w_idle ? bus.MemRead  : r_read;
    assign w_write  = w_idle ? bus.MemWrite : r_write;
    assign w_be     = w_idle ? bus.BE       : r_be;
    assign w_funct3 = w_idle ? bus.funct3   : r_funct3;
    assign w_addr   = w_idle ? bus.addr     : r_addr;
    assign w_wdata  = w_idle ? bus.wdata    : r_wdata;

    assign w_idx  = w_addr[IdxW+1:2];
    assign w_off  = w_addr[1:0];
    assign w_word = r_mem[w_idx];

    assign w_base_err = (w_read == w_write)
                      || !((w_be == BE_BYTE) || (w_be == BE_HALF) || (w_be == BE_WORD))
                      || ((w_be == BE_HALF) && w_addr[0])
                      || ((w_be == BE_WORD) && (w_addr[1:0] != 2'd0))
                      || ((w_addr >> (IdxW + 2)) != 32'd0);

    load_align u_load_align (
        .word   (w_word),
        .offset (w_off),
        .funct3 (w_funct3),
        .data   (w_load_data),
        .err    (w_align_err)
    );

    assign w_err    = w_base_err || (w_read && w_align_err);
    assign w_mask   = w_be << w_off;
    assign w_wshift = w_wdata << {w_off, 3'b000};
    assign w_commit = !RST && (r_state != StResp) && (w_state_next == StResp)
                    && w_write && !w_err;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle: begin
                if (bus.req_valid) begin
                    w_state_next = (LATENCY == 0) ? StResp : StWait;
                end
            end
            StWait: begin
                if (r_cnt == '0) begin
                    w_state_next = StResp;
                end
            end
            StResp:  w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_cnt    <= '0;
            r_read   <= 1'b0;
            r_write  <= 1'b0;
            r_be     <= '0;
            r_funct3 <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
        end else if (w_idle && bus.req_valid) begin
            r_cnt    <= (LATENCY > 0) ? CntW'(LATENCY - 1) : '0;
            r_read   <= bus.MemRead;
            r_write  <= bus.MemWrite;
            r_be     <= bus.BE;
            r_funct3 <= bus.funct3;
            r_addr   <= bus.addr;
            r_wdata  <= bus.wdata;
        end else if ((r_state == StWait) && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    // Array is deliberately outside reset so its contents survive RST.
    always_ff @(posedge CLK) begin
        if (w_commit) begin
            for (int b = 0; b < 4; b++) begin
                if (w_mask[b]) begin
                    r_mem[w_idx][8*b +: 8] <= w_wshift[8*b +: 8];
                end
            end
        end
    end

    always_comb begin
        w_resp         = (r_state == StResp);
        bus.req_ready  = w_idle && !RST;
        bus.resp_valid = w_resp;
        bus.resp_err   = w_resp && w_err;
        bus.rdata      = (w_resp && !w_err && w_read) ? w_load_data : 32'd0;
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench: LATENCY=2 instance for load/store/error/reset cases and a
// LATENCY=0 instance for back-to-back throughput.
module tb_data_mem_responder;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_vec;
    int   n_fail;

    data_mem_responder_if bus_a ();
    data_mem_responder_if bus_b ();

    data_mem_responder #(.DEPTH(256), .LATENCY(2)) u_dut_a (
        .CLK (clk),
        .RST (rst_a),
        .bus (bus_a)
    );

    data_mem_responder #(.DEPTH(256), .LATENCY(0)) u_dut_b (
        .CLK (clk),
        .RST (rst_b),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // One request on instance A; returns response data/err and the cycle it arrived.
    task automatic req_a(input logic rd, input logic wr, input logic [3:0] be,
                         input logic [2:0] f3, input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] rdat, output logic err, output int cyc);
        @(negedge clk);
        bus_a.req_valid = 1'b1;
        bus_a.MemRead   = rd;
        bus_a.MemWrite  = wr;
        bus_a.BE        = be;
        bus_a.funct3    = f3;
        bus_a.addr      = ad;
        bus_a.wdata     = wd;
        check("req_ready_idle", {31'd0, bus_a.req_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        bus_a.MemRead   = ~rd;
        bus_a.MemWrite  = ~wr;
        bus_a.BE        = 4'b0110;
        bus_a.funct3    = 3'b111;
        bus_a.addr      = 32'hFFFF_FFFF;
        bus_a.wdata     = 32'h5A5A_5A5A;
        cyc = 1;
        while (!bus_a.resp_valid && cyc < 8) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        rdat = bus_a.rdata;
        err  = bus_a.resp_err;
        @(posedge clk);
        #1;
        check("resp_pulse_end", {31'd0, bus_a.resp_valid}, 32'd0);
        check("rdata_idle_zero", bus_a.rdata, 32'd0);
    endtask

    task automatic store_a(input string tag, input logic [3:0] be, input logic [2:0] f3,
                           input logic [31:0] ad, input logic [31:0] wd);
        logic [31:0] rdat;
        logic        err;
        int          cyc;
        req_a(1'b0, 1'b1, be, f3, ad, wd, rdat, err, cyc);
        check({tag, "_lat"}, cyc, 32'd3);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
    endtask

    task automatic load_a(input string tag, input logic [3:0] be, input logic [2:0] f3,
                          input logic [31:0] ad, input logic [31:0] exp);
        logic [31:0] rdat;
        logic        err;
        int          cyc;
        req_a(1'b1, 1'b0, be, f3, ad, 32'd0, rdat, err, cyc);
        check({tag, "_lat"}, cyc, 32'd3);
        check({tag, "_err"}, {31'd0, err}, 32'd0);
        check({tag, "_data"}, rdat, exp);
    endtask

    task automatic bad_a(input string tag, input logic rd, input logic wr, input logic [3:0] be,
                         input logic [2:0] f3, input logic [31:0] ad);
        logic [31:0] rdat;
        logic        err;
        int          cyc;
        req_a(rd, wr, be, f3, ad, 32'h0BAD_0BAD, rdat, err, cyc);
        check({tag, "_lat"}, cyc, 32'd3);
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        check({tag, "_data"}, rdat, 32'd0);
    endtask

    initial begin
        int seen;
        n_vec  = 0;
        n_fail = 0;
        bus_a.req_valid = 1'b0;
        bus_a.MemRead   = 1'b0;
        bus_a.MemWrite  = 1'b0;
        bus_a.BE        = 4'd0;
        bus_a.funct3    = 3'd0;
        bus_a.addr      = 32'd0;
        bus_a.wdata     = 32'd0;
        bus_b.req_valid = 1'b0;
        bus_b.MemRead   = 1'b0;
        bus_b.MemWrite  = 1'b0;
        bus_b.BE        = 4'd0;
        bus_b.funct3    = 3'd0;
        bus_b.addr      = 32'd0;
        bus_b.wdata     = 32'd0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_resp_valid", {31'd0, bus_a.resp_valid}, 32'd0);
        check("rst_resp_err", {31'd0, bus_a.resp_err}, 32'd0);
        check("rst_rdata", bus_a.rdata, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;
        #1;
        check("rst_ready_a", {31'd0, bus_a.req_ready}, 32'd1);
        check("rst_ready_b", {31'd0, bus_b.req_ready}, 32'd1);

        store_a("sw_10", 4'b1111, 3'b010, 32'h10, 32'hDEAD_BEEF);
        load_a("lw_10", 4'b1111, 3'b010, 32'h10, 32'hDEAD_BEEF);

        store_a("sw_20", 4'b1111, 3'b010, 32'h20, 32'h80FF_7F01);
        load_a("lb_23", 4'b0001, 3'b000, 32'h23, 32'hFFFF_FF80);
        load_a("lbu_23", 4'b0001, 3'b100, 32'h23, 32'h0000_0080);
        load_a("lh_22", 4'b0011, 3'b001, 32'h22, 32'hFFFF_80FF);
        load_a("lhu_20", 4'b0011, 3'b101, 32'h20, 32'h0000_7F01);
        load_a("lb_21", 4'b0001, 3'b000, 32'h21, 32'h0000_007F);

        store_a("sw_20b", 4'b1111, 3'b010, 32'h20, 32'h1122_3344);
        store_a("sb_21", 4'b0001, 3'b000, 32'h21, 32'h0000_00AA);
        load_a("lw_20_sb", 4'b1111, 3'b010, 32'h20, 32'h1122_AA44);
        store_a("sh_22", 4'b0011, 3'b001, 32'h22, 32'h0000_BEEF);
        load_a("lw_20_sh", 4'b1111, 3'b010, 32'h20, 32'hBEEF_AA44);

        bad_a("lw_06", 1'b1, 1'b0, 4'b1111, 3'b010, 32'h06);
        bad_a("lh_03", 1'b1, 1'b0, 4'b0011, 3'b001, 32'h03);
        bad_a("rd_and_wr", 1'b1, 1'b1, 4'b1111, 3'b010, 32'h10);
        bad_a("no_rd_wr", 1'b0, 1'b0, 4'b1111, 3'b010, 32'h10);
        bad_a("sw_12", 1'b0, 1'b1, 4'b1111, 3'b010, 32'h12);
        bad_a("sh_21", 1'b0, 1'b1, 4'b0011, 3'b001, 32'h21);
        bad_a("bad_be", 1'b0, 1'b1, 4'b0111, 3'b010, 32'h10);
        bad_a("hi_addr", 1'b0, 1'b1, 4'b1111, 3'b010, 32'h410);
        bad_a("bad_f3", 1'b1, 1'b0, 4'b1111, 3'b011, 32'h10);
        load_a("lw_10_kept", 4'b1111, 3'b010, 32'h10, 32'hDEAD_BEEF);
        load_a("lw_20_kept", 4'b1111, 3'b010, 32'h20, 32'hBEEF_AA44);

        // Reset pulsed in the first WAIT cycle must abort the store.
        store_a("sw_30", 4'b1111, 3'b010, 32'h30, 32'h0102_0304);
        @(negedge clk);
        bus_a.req_valid = 1'b1;
        bus_a.MemRead   = 1'b0;
        bus_a.MemWrite  = 1'b1;
        bus_a.BE        = 4'b1111;
        bus_a.funct3    = 3'b010;
        bus_a.addr      = 32'h30;
        bus_a.wdata     = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        bus_a.req_valid = 1'b0;
        check("wait_not_ready", {31'd0, bus_a.req_ready}, 32'd0);
        #1;
        rst_a = 1'b1;
        #1;
        check("abort_no_resp", {31'd0, bus_a.resp_valid}, 32'd0);
        @(negedge clk);
        rst_a = 1'b0;
        #1;
        check("abort_ready", {31'd0, bus_a.req_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            if (bus_a.resp_valid) seen++;
        end
        check("abort_resp_count", seen, 32'd0);
        load_a("lw_30_kept", 4'b1111, 3'b010, 32'h30, 32'h0102_0304);

        // LATENCY=0 with req_valid held high.
        @(negedge clk);
        bus_b.req_valid = 1'b1;
        bus_b.MemRead   = 1'b0;
        bus_b.MemWrite  = 1'b1;
        bus_b.BE        = 4'b1111;
        bus_b.funct3    = 3'b010;
        bus_b.addr      = 32'h40;
        bus_b.wdata     = 32'h0000_0055;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("b2b_valid_%0d", i), {31'd0, bus_b.resp_valid},
                  (i % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("b2b_ready_%0d", i), {31'd0, bus_b.req_ready},
                  (i % 2 == 0) ? 32'd0 : 32'd1);
            check($sformatf("b2b_err_%0d", i), {31'd0, bus_b.resp_err}, 32'd0);
        end
        @(negedge clk);
        bus_b.MemRead  = 1'b1;
        bus_b.MemWrite = 1'b0;
        @(posedge clk);
        #1;
        bus_b.req_valid = 1'b0;
        check("b_lw_valid", {31'd0, bus_b.resp_valid}, 32'd1);
        check("b_lw_data", bus_b.rdata, 32'h0000_0055);
        @(posedge clk);
        #1;
        check("b_lw_end", {31'd0, bus_b.resp_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
